// File: rtl/rock_sequencer.sv
// Searches the rocking amplitude/frequency (A/F) for the lowest stress and holds it once the baby is calm.
// Define AVERAGE_EN to average four stress samples per measurement instead of one.
module rock_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [8:0]  CALM_THR      = 9'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] huilVolume,
  input  logic [7:0] hartRitme,
  output logic [3:0] A,
  output logic [3:0] F,
  output logic       busy,
  output logic       calm
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, MEASURE, DECIDE, CALM} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] a_nxt, f_nxt;
  logic [3:0] best_a, best_f, best_a_nxt, best_f_nxt;
  logic [8:0] best, best_nxt, best_dec;
  logic [1:0] idx, idx_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [8:0] meas, meas_nxt;
  logic [8:0] stress;
  logic [3:0] cand_a, cand_f;
  logic       cand_ok;
`ifdef AVERAGE_EN
  logic [10:0] acc, acc_nxt, acc_sum;
`endif

  assign stress = {1'b0, huilVolume} + {1'b0, hartRitme};
  assign busy   = (state != IDLE);
  assign calm   = (state == CALM);

  // Trial order: F-1, A-1, F+1, A+1, always relative to the best setting.
  always_comb begin
    cand_a  = best_a;
    cand_f  = best_f;
    cand_ok = 1'b1;
    case (idx)
      2'd0: begin cand_f = best_f - 4'd1; cand_ok = (best_f != 4'd0);  end
      2'd1: begin cand_a = best_a - 4'd1; cand_ok = (best_a != 4'd0);  end
      2'd2: begin cand_f = best_f + 4'd1; cand_ok = (best_f != 4'd15); end
      default: begin cand_a = best_a + 4'd1; cand_ok = (best_a != 4'd15); end
    endcase
  end

  always_comb begin
    state_nxt  = state;
    a_nxt      = A;
    f_nxt      = F;
    best_a_nxt = best_a;
    best_f_nxt = best_f;
    best_nxt   = best;
    best_dec   = best;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    meas_nxt   = meas;
`ifdef AVERAGE_EN
    acc_nxt    = acc;
    acc_sum    = acc + {2'b00, stress};
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = APPLY;
          best_nxt   = 9'h1FF;
          idx_nxt    = 2'd0;
          best_a_nxt = A;
          best_f_nxt = F;
        end
      end
      APPLY: begin
        if (cand_ok) begin
          a_nxt     = cand_a;
          f_nxt     = cand_f;
          cnt_nxt   = SETTLE_LOAD;
          state_nxt = SETTLE;
        end else begin
          idx_nxt = idx + 2'd1;
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          state_nxt = MEASURE;
`ifdef AVERAGE_EN
          acc_nxt   = 11'd0;
`endif
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      MEASURE: begin
`ifdef AVERAGE_EN
        // cnt is zero on entry and doubles as the sample index here.
        if (cnt[1:0] == 2'd3) begin
          meas_nxt  = 9'(acc_sum >> 2);
          state_nxt = DECIDE;
        end else begin
          acc_nxt = acc_sum;
          cnt_nxt = cnt + 8'd1;
        end
`else
        meas_nxt  = stress;
        state_nxt = DECIDE;
`endif
      end
      DECIDE: begin
        if (meas < best) begin
          best_nxt   = meas;
          best_dec   = meas;
          best_a_nxt = A;
          best_f_nxt = F;
          idx_nxt    = 2'd0;
        end else begin
          a_nxt   = best_a;
          f_nxt   = best_f;
          idx_nxt = idx + 2'd1;
        end
        if (best_dec <= CALM_THR) begin
          state_nxt = CALM;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          state_nxt = APPLY;
        end
      end
      CALM: begin
        if (cnt == 8'd0) begin
          if (stress > CALM_THR) begin
            best_nxt  = 9'h1FF;
            idx_nxt   = 2'd0;
            state_nxt = APPLY;
          end else begin
            cnt_nxt = SETTLE_LOAD;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      A      <= 4'd8;
      F      <= 4'd8;
      best_a <= 4'd8;
      best_f <= 4'd8;
      best   <= 9'h1FF;
      idx    <= 2'd0;
      cnt    <= 8'd0;
      meas   <= 9'd0;
`ifdef AVERAGE_EN
      acc    <= 11'd0;
`endif
    end else begin
      state  <= state_nxt;
      A      <= a_nxt;
      F      <= f_nxt;
      best_a <= best_a_nxt;
      best_f <= best_f_nxt;
      best   <= best_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      meas   <= meas_nxt;
`ifdef AVERAGE_EN
      acc    <= acc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rock_sequencer.sv
// Self-checking bench for rock_sequencer: a vector table for the start-up sequence, then
// stress landscapes over (A,F) walked by a trial-level reference model.
module tb_rock_sequencer;
  localparam int S = 4;
  localparam int THR = 64;
`ifdef AVERAGE_EN
  localparam int M = 4;
`else
  localparam int M = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] huil, hart;
  logic [3:0] a, f;
  logic       busy, calm;

  rock_sequencer #(.SETTLE_CYCLES(S), .CALM_THR(9'(THR))) dut (
    .clk(clk), .reset(reset), .start(start),
    .huilVolume(huil), .hartRitme(hart),
    .A(a), .F(f), .busy(busy), .calm(calm)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int land [16][16];

  // Reference model: best setting, best stress, trial index, calm flag.
  int  b_a, b_f, best, idx;
  bit  in_calm;

  typedef struct {
    bit start;
    int s;
    int ea, ef;
    bit eb, ec;
  } vec_t;

  task automatic drive_stress(input int s);
    int lo, hi, h;
    lo = (s > 255) ? s - 255 : 0;
    hi = (s < 255) ? s : 255;
    h  = int'($urandom_range(hi, lo));
    huil = 8'(h);
    hart = 8'(s - h);
  endtask

  function automatic int junk();
    return int'($urandom_range(510, 0));
  endfunction

  // Averaged builds see samples spread around the landscape value; their mean is unchanged.
  function automatic int meas_val(input int v, input int j);
`ifdef AVERAGE_EN
    if (v >= 50 && v <= 460) return (j % 2 == 1) ? v + 50 : v - 50;
    return v;
`else
    if (j < 0) return 0;
    return v;
`endif
  endfunction

  task automatic expect_out(input int ea, input int ef, input bit eb, input bit ec, input string name);
    checks++;
    if (a !== 4'(ea) || f !== 4'(ef) || busy !== eb || calm !== ec) begin
      errors++;
      $display("FAIL %s: got A=%0d F=%0d busy=%0b calm=%0b, want A=%0d F=%0d busy=%0b calm=%0b",
               name, a, f, busy, calm, ea, ef, eb, ec);
    end
  endtask

  // Called just after a falling edge: check this cycle's outputs, drive its stress, advance one cycle.
  task automatic step(input int ea, input int ef, input bit eb, input bit ec, input int s, input string name);
    expect_out(ea, ef, eb, ec, name);
    drive_stress(s);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    start = 1'b0;
    #1;
    expect_out(8, 8, 1'b0, 1'b0, name);
    @(negedge clk);
    reset = 1'b0;
    b_a = 8; b_f = 8; best = 511; idx = 0; in_calm = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(b_a, b_f, 1'b0, 1'b0, junk(), "idle_start");
    start = 1'b0;
    best = 511; idx = 0; in_calm = 1'b0;
  endtask

  task automatic seg_trial();
    int ca, cf, ms;
    bit ok;
    ca = b_a; cf = b_f;
    case (idx)
      0: cf = b_f - 1;
      1: ca = b_a - 1;
      2: cf = b_f + 1;
      default: ca = b_a + 1;
    endcase
    ok = (ca >= 0 && ca <= 15 && cf >= 0 && cf <= 15);
    step(b_a, b_f, 1'b1, 1'b0, junk(), ok ? "apply" : "apply_skip");
    if (!ok) begin
      idx = (idx + 1) % 4;
      return;
    end
    for (int i = 0; i < S; i++) step(ca, cf, 1'b1, 1'b0, junk(), "settle");
    for (int j = 0; j < M; j++) step(ca, cf, 1'b1, 1'b0, meas_val(land[ca][cf], j), "measure");
    step(ca, cf, 1'b1, 1'b0, junk(), "decide");
    ms = land[ca][cf];
    if (ms < best) begin
      best = ms; b_a = ca; b_f = cf; idx = 0;
    end else begin
      idx = (idx + 1) % 4;
    end
    in_calm = (best <= THR);
  endtask

  // One calm sampling period: only its last cycle is sampled.
  task automatic seg_calm();
    for (int i = 0; i < S - 1; i++) step(b_a, b_f, 1'b1, 1'b1, junk(), "calm_hold");
    step(b_a, b_f, 1'b1, 1'b1, land[b_a][b_f], "calm_sample");
    if (land[b_a][b_f] > THR) begin
      best = 511; idx = 0; in_calm = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      if (in_calm) seg_calm();
      else seg_trial();
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) land[i][j] = v;
  endtask

  vec_t vecs [6];

  initial begin
    reset = 1'b1; start = 1'b0; huil = 8'd0; hart = 8'd0;
    fill_const(300);

    // Start-up table, stopping mid-settle on the first F-1 candidate.
    vecs[0] = '{start: 1'b0, s: 300, ea: 8, ef: 8, eb: 1'b0, ec: 1'b0};
    vecs[1] = '{start: 1'b1, s: 0,   ea: 8, ef: 8, eb: 1'b0, ec: 1'b0};
    vecs[2] = '{start: 1'b0, s: 510, ea: 8, ef: 8, eb: 1'b1, ec: 1'b0};
    vecs[3] = '{start: 1'b1, s: 20,  ea: 8, ef: 7, eb: 1'b1, ec: 1'b0};
    vecs[4] = '{start: 1'b0, s: 400, ea: 8, ef: 7, eb: 1'b1, ec: 1'b0};
    vecs[5] = '{start: 1'b1, s: 1,   ea: 8, ef: 7, eb: 1'b1, ec: 1'b0};

    @(negedge clk);
    do_reset("reset_initial");
    for (int i = 0; i < 6; i++) begin
      start = vecs[i].start;
      step(vecs[i].ea, vecs[i].ef, vecs[i].eb, vecs[i].ec, vecs[i].s, $sformatf("vec%0d", i));
    end
    start = 1'b0;
    do_reset("reset_mid_settle");

    // Bowl with its minimum at A=3, F=13; never calm.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        land[i][j] = 70 + 3 * ((i > 3) ? i - 3 : 3 - i) + 4 * ((j > 13) ? j - 13 : 13 - j);
    do_start();
    run(70);
    do_reset("reset_after_bowl");

    // Minimum at F=0 so F-1 has to be skipped there.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        land[i][j] = 100 + 5 * j + 20 * ((i > 8) ? i - 8 : 8 - i);
    do_start();
    run(40);
    do_reset("reset_after_corner");

    // Calm at the first trial, then disturbed.
    fill_const(60);
    do_start();
    run(4);
    fill_const(100);
    run(10);
    do_reset("reset_after_calm");

    // Flat landscape: every later trial ties and reverts.
    fill_const(150);
    do_start();
    run(14);
    do_reset("reset_after_flat");

    // Random landscapes, some reaching calm.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) land[i][j] = int'($urandom_range(510, 30));
      do_start();
      run(50);
      do_reset($sformatf("reset_after_rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
